// File: rtl/axi_config_master.sv
// axi_config_master: turns single-word register read/write requests into single-beat AXI4 master transactions
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   wr, waddr, wdata, wstrb        write request (sampled when ready=1)
//   rd, raddr                      read request (sampled when ready=1; loses to wr)
//   ready                          idle, request can be accepted this cycle
//   wdone, rvalid, err             one-cycle completion pulses
//   rdata, resp                    last read data / last response, held
//   m_axi_aw*, m_axi_w*, m_axi_b*  AXI4 write channels
//   m_axi_ar*, m_axi_r*            AXI4 read channels
module axi_config_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int AXI_ID     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  input  logic                  rd,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic                  ready,
  output logic                  wdone,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic [1:0]            resp,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic [3:0]            m_axi_awqos,
  output logic [3:0]            m_axi_awregion,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic [3:0]            m_axi_arqos,
  output logic [3:0]            m_axi_arregion,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);
  typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R} state_t;
  localparam logic [2:0]          AXSIZE = 3'($clog2(STRB_WIDTH));
  localparam logic [ID_WIDTH-1:0] ID     = ID_WIDTH'(AXI_ID);
  state_t                  state_q, state_d;
  logic                    awv_q, awv_d, wv_q, wv_d, arv_q, arv_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
  logic [1:0]              resp_q, resp_d;
  logic                    wdone_q, wdone_d, rvalid_q, rvalid_d, err_q, err_d;
  logic                    acc_wr, acc_rd, b_hs, r_hs, r_done;
  logic                    unused_ids;
  assign unused_ids = ^{m_axi_bid, m_axi_rid};
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      awv_q    <= 1'b0;
      wv_q     <= 1'b0;
      arv_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      resp_q   <= '0;
      wdone_q  <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      awv_q    <= awv_d;
      wv_q     <= wv_d;
      arv_q    <= arv_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rdata_q  <= rdata_d;
      resp_q   <= resp_d;
      wdone_q  <= wdone_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end
  // AW and W are tracked separately: each valid drops on its own handshake
  always_comb begin
    acc_wr   = state_q == IDLE && wr;
    acc_rd   = state_q == IDLE && !wr && rd;
    b_hs     = state_q == WR_B && m_axi_bvalid;
    r_hs     = state_q == RD_R && m_axi_rvalid;
    r_done   = r_hs && m_axi_rlast;
    awv_d    = acc_wr || (awv_q && !m_axi_awready);
    wv_d     = acc_wr || (wv_q && !m_axi_wready);
    arv_d    = acc_rd || (arv_q && !m_axi_arready);
    addr_d   = acc_wr ? waddr : acc_rd ? raddr : addr_q;
    wdata_d  = acc_wr ? wdata : wdata_q;
    wstrb_d  = acc_wr ? wstrb : wstrb_q;
    rdata_d  = r_hs ? m_axi_rdata : rdata_q;
    resp_d   = b_hs ? m_axi_bresp : r_hs ? m_axi_rresp : resp_q;
    wdone_d  = b_hs;
    rvalid_d = r_done;
    err_d    = (b_hs && m_axi_bresp != 2'b00) || (r_done && m_axi_rresp != 2'b00);
    state_d  = state_q;
    case (state_q)
      IDLE:    state_d = wr ? WR_AW_W : rd ? RD_AR : IDLE;
      WR_AW_W: state_d = (!awv_q || m_axi_awready) && (!wv_q || m_axi_wready) ? WR_B : WR_AW_W;
      WR_B:    state_d = m_axi_bvalid ? IDLE : WR_B;
      RD_AR:   state_d = m_axi_arready ? RD_R : RD_AR;
      RD_R:    state_d = r_done ? IDLE : RD_R;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    ready        = state_q == IDLE;
    m_axi_bready = state_q == WR_B;
    m_axi_rready = state_q == RD_R;
  end
  assign wdone          = wdone_q;
  assign rvalid         = rvalid_q;
  assign rdata          = rdata_q;
  assign err            = err_q;
  assign resp           = resp_q;
  assign m_axi_awid     = ID;
  assign m_axi_awaddr   = addr_q;
  assign m_axi_awlen    = 8'd0;
  assign m_axi_awsize   = AXSIZE;
  assign m_axi_awburst  = 2'b01;
  assign m_axi_awlock   = 1'b0;
  assign m_axi_awcache  = 4'b0011;
  assign m_axi_awprot   = 3'd0;
  assign m_axi_awqos    = 4'd0;
  assign m_axi_awregion = 4'd0;
  assign m_axi_awvalid  = awv_q;
  assign m_axi_wdata    = wdata_q;
  assign m_axi_wstrb    = wstrb_q;
  assign m_axi_wlast    = 1'b1;
  assign m_axi_wvalid   = wv_q;
  assign m_axi_arid     = ID;
  assign m_axi_araddr   = addr_q;
  assign m_axi_arlen    = 8'd0;
  assign m_axi_arsize   = AXSIZE;
  assign m_axi_arburst  = 2'b01;
  assign m_axi_arlock   = 1'b0;
  assign m_axi_arcache  = 4'b0011;
  assign m_axi_arprot   = 3'd0;
  assign m_axi_arqos    = 4'd0;
  assign m_axi_arregion = 4'd0;
  assign m_axi_arvalid  = arv_q;
endmodule

// File: tb/tb_axi_config_master.sv
// tb_axi_config_master: directed and randomized transactions against a delay-configurable AXI slave model
module tb_axi_config_master;
  localparam int IW = 8;
  localparam logic [36:0] AX_EXP = {8'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0, 4'd0, 8'd5};
  logic clk = 1'b0, rst;
  always #5 clk = ~clk;
  logic wr, rd, ready, wdone, rvalid, err;
  logic [31:0] waddr, raddr, wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] resp;
  logic [IW-1:0] awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, m_wdata, m_rdata;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize, awprot, arprot;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awlock, arlock, awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, m_rvalid, rready;
  logic [3:0] awcache, arcache, awqos, arqos, awregion, arregion, m_wstrb;
  axi_config_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4), .ID_WIDTH(IW), .AXI_ID(5)) dut (
    .clk(clk), .rst(rst), .wr(wr), .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .rd(rd), .raddr(raddr),
    .ready(ready), .wdone(wdone), .rvalid(rvalid), .rdata(rdata), .err(err), .resp(resp),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache), .m_axi_awprot(awprot),
    .m_axi_awqos(awqos), .m_axi_awregion(awregion), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
    .m_axi_wready(wready), .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
    .m_axi_bready(bready), .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
    .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
    .m_axi_arprot(arprot), .m_axi_arqos(arqos), .m_axi_arregion(arregion), .m_axi_arvalid(arvalid),
    .m_axi_arready(arready), .m_axi_rid(rid), .m_axi_rdata(m_rdata), .m_axi_rresp(rresp),
    .m_axi_rlast(rlast), .m_axi_rvalid(m_rvalid), .m_axi_rready(rready));
  // slave model: each ready rises after its valid has waited *_dly cycles; responses follow after *_dly more
  int aw_dly, w_dly, b_dly, ar_dly, r_dly;
  logic [1:0] s_bresp, s_rresp;
  logic [31:0] s_rdata;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic aw_got, w_got, ar_got, aw_wait, w_wait, ar_wait;
  logic [31:0] aw_hold, w_hold, ar_hold;
  int n_aw, n_w, n_ar, viol;
  logic [31:0] c_awaddr, c_araddr, c_wdata;
  logic [3:0] c_wstrb;
  logic c_wlast;
  logic [36:0] c_aw, c_ar;
  assign awready  = awvalid && aw_cnt >= aw_dly;
  assign wready   = wvalid && w_cnt >= w_dly;
  assign arready  = arvalid && ar_cnt >= ar_dly;
  assign bvalid   = aw_got && w_got && b_cnt >= b_dly;
  assign m_rvalid = ar_got && r_cnt >= r_dly;
  assign bresp = s_bresp;
  assign rresp = s_rresp;
  assign m_rdata = s_rdata;
  assign rlast = 1'b1;
  assign bid = 8'hA5;
  assign rid = 8'h5A;
  always @(posedge clk) begin
    if (rst) begin
      {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} <= '0;
      {aw_got, w_got, ar_got, aw_wait, w_wait, ar_wait} <= '0;
    end else begin
      if ((aw_wait && (!awvalid || awaddr != aw_hold)) || (w_wait && (!wvalid || m_wdata != w_hold))
          || (ar_wait && (!arvalid || araddr != ar_hold)) || (bready && !(aw_got && w_got))
          || (rready && !ar_got) || (awvalid && aw_got) || (wvalid && w_got) || (arvalid && ar_got))
        viol <= viol + 1;
      aw_wait <= awvalid && !awready;
      w_wait <= wvalid && !wready;
      ar_wait <= arvalid && !arready;
      aw_hold <= awaddr;
      w_hold <= m_wdata;
      ar_hold <= araddr;
      if (awvalid && awready) begin
        aw_got <= 1'b1; aw_cnt <= 0; n_aw <= n_aw + 1; c_awaddr <= awaddr;
        c_aw <= {awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awid};
      end else if (awvalid) aw_cnt <= aw_cnt + 1;
      if (wvalid && wready) begin
        w_got <= 1'b1; w_cnt <= 0; n_w <= n_w + 1; c_wdata <= m_wdata; c_wstrb <= m_wstrb; c_wlast <= wlast;
      end else if (wvalid) w_cnt <= w_cnt + 1;
      if (bvalid && bready) begin
        aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
      end else if (aw_got && w_got) b_cnt <= b_cnt + 1;
      if (arvalid && arready) begin
        ar_got <= 1'b1; ar_cnt <= 0; n_ar <= n_ar + 1; c_araddr <= araddr;
        c_ar <= {arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arid};
      end else if (arvalid) ar_cnt <= ar_cnt + 1;
      if (m_rvalid && rready) begin
        ar_got <= 1'b0; r_cnt <= 0;
      end else if (ar_got) r_cnt <= r_cnt + 1;
    end
  end
  int tests = 0, fails = 0;
  logic [31:0] mdl_rdata;
  logic [1:0] mdl_resp;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] br, input int ad, input int wd, input int bd);
    int k, naw0, nw0, nar0, lat;
    logic busy;
    aw_dly = ad; w_dly = wd; b_dly = bd; s_bresp = br;
    lat = 2 + (ad > wd ? ad : wd) + bd;
    naw0 = n_aw; nw0 = n_w; nar0 = n_ar;
    chk("wr_ready_idle", ready, 1);
    chk("resp_held", resp, mdl_resp);
    wr = 1'b1; waddr = a; wdata = d; wstrb = s;
    @(posedge clk);
    #1 wr = 1'b0; waddr = $urandom; wdata = $urandom; wstrb = 4'($urandom);
    @(negedge clk);
    k = 0;
    busy = 1'b1;
    chk("wr_pulse_clear", {wdone, rvalid, err}, 0);
    while (!wdone && k < 200) begin
      if (ready) busy = 1'b0;
      @(negedge clk);
      k++;
    end
    mdl_resp = br;
    chk("wr_busy", busy, 1);
    chk("wr_latency", k, lat);
    chk("wr_ready_done", ready, 1);
    chk("wr_err", err, br != 2'b00);
    chk("wr_resp", resp, br);
    chk("wr_rvalid_quiet", rvalid, 0);
    chk("wr_rdata_held", rdata, mdl_rdata);
    chk("aw_addr", c_awaddr, a);
    chk("aw_fields", c_aw, AX_EXP);
    chk("w_data", c_wdata, d);
    chk("w_strb", c_wstrb, s);
    chk("w_last", c_wlast, 1);
    chk("wr_counts", {8'(n_aw - naw0), 8'(n_w - nw0), 8'(n_ar - nar0)}, {8'd1, 8'd1, 8'd0});
  endtask
  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] rr,
                         input int ad, input int rdl);
    int k, naw0, nar0, lat;
    logic busy;
    ar_dly = ad; r_dly = rdl; s_rresp = rr; s_rdata = d;
    lat = 2 + ad + rdl;
    naw0 = n_aw; nar0 = n_ar;
    chk("rd_ready_idle", ready, 1);
    chk("rdata_held", rdata, mdl_rdata);
    rd = 1'b1; raddr = a;
    @(posedge clk);
    #1 rd = 1'b0; raddr = $urandom;
    s_rdata = $urandom;
    @(negedge clk);
    s_rdata = d;
    k = 0;
    busy = 1'b1;
    chk("rd_pulse_clear", {wdone, rvalid, err}, 0);
    while (!rvalid && k < 200) begin
      if (ready) busy = 1'b0;
      @(negedge clk);
      k++;
    end
    mdl_rdata = d;
    mdl_resp = rr;
    chk("rd_busy", busy, 1);
    chk("rd_latency", k, lat);
    chk("rd_ready_done", ready, 1);
    chk("rd_data", rdata, d);
    chk("rd_err", err, rr != 2'b00);
    chk("rd_resp", resp, rr);
    chk("rd_wdone_quiet", wdone, 0);
    chk("ar_addr", c_araddr, a);
    chk("ar_fields", c_ar, AX_EXP);
    chk("rd_counts", {8'(n_aw - naw0), 8'(n_ar - nar0)}, {8'd0, 8'd1});
  endtask
  task automatic chk_reset_state(input string tag);
    chk(tag, {ready, awvalid, wvalid, arvalid, bready, rready, wdone, rvalid, err, resp, rdata},
        {1'b1, 8'b0, 2'b00, 32'h0});
  endtask
  int nar_s;
  logic [31:0] ra, rv;
  logic [3:0] rs;
  logic [1:0] rr2;
  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; waddr = '0; raddr = '0; wdata = '0; wstrb = '0;
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    s_bresp = 2'b00; s_rresp = 2'b00; s_rdata = '0;
    mdl_rdata = '0; mdl_resp = 2'b00;
    repeat (2) @(negedge clk);
    chk_reset_state("reset_values");
    rst = 1'b0;
    do_write(32'h10, 32'hDEADBEEF, 4'hF, 2'b00, 0, 0, 0);
    do_read(32'h20, 32'h12345678, 2'b00, 0, 4);
    do_write(32'h30, 32'h0BADF00D, 4'h3, 2'b00, 3, 0, 0);
    do_write(32'h34, 32'hCAFEBABE, 4'hC, 2'b00, 0, 3, 1);
    rd = 1'b1; raddr = 32'h44;
    nar_s = n_ar;
    do_write(32'h40, 32'h11112222, 4'hF, 2'b00, 1, 1, 0);
    chk("wr_wins_no_ar", n_ar - nar_s, 0);
    do_read(32'h44, 32'h33334444, 2'b00, 0, 0);
    do_write(32'h50, 32'h55556666, 4'hF, 2'b10, 0, 0, 2);
    do_read(32'h54, 32'h77778888, 2'b11, 2, 1);
    aw_dly = 0; w_dly = 0; b_dly = 10;
    wr = 1'b1; waddr = 32'h60; wdata = 32'h1; wstrb = 4'hF;
    @(posedge clk);
    #1 wr = 1'b0;
    repeat (2) @(negedge clk);
    chk("in_wr_b", {bready, ready}, 2'b10);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state("reset_in_wr_b");
    rst = 1'b0;
    mdl_rdata = '0; mdl_resp = 2'b00;
    ar_dly = 10;
    rd = 1'b1; raddr = 32'h64;
    @(posedge clk);
    #1 rd = 1'b0;
    @(negedge clk);
    chk("in_rd_ar", {arvalid, ready}, 2'b10);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state("reset_in_rd_ar");
    rst = 1'b0;
    do_write(32'h70, 32'h9999AAAA, 4'h5, 2'b00, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      ra = $urandom & 32'hFFFF_FFFC;
      rv = $urandom;
      rs = 4'($urandom);
      rr2 = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 1) == 0)
        do_write(ra, rv, rs, rr2, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
      else
        do_read(ra, rv, rr2, $urandom_range(0, 4), $urandom_range(0, 4));
    end
    @(negedge clk);
    chk("final_pulses_low", {wdone, rvalid, err}, 0);
    chk("protocol_violations", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
